// File: rtl/timer_pkg.sv
// timer_pkg: shared constants, register-select type and address decode for the timer peripheral
package timer_pkg;

    localparam logic [31:0] KERNEL_BASE = 32'h4000_0000;
    localparam int          WIN_BITS    = 5;

    localparam logic [WIN_BITS-1:0] TH_OFS      = 5'h00;
    localparam logic [WIN_BITS-1:0] TL_OFS      = 5'h04;
    localparam logic [WIN_BITS-1:0] TCON_OFS    = 5'h08;
    localparam logic [WIN_BITS-1:0] SYSTICK_OFS = 5'h14;

    localparam int EN_BIT = 0;
    localparam int IE_BIT = 1;
    localparam int ST_BIT = 2;

    typedef enum logic [2:0] {
        REG_NONE,
        REG_TH,
        REG_TL,
        REG_TCON,
        REG_SYSTICK
    } reg_sel_e;

    // Word index within the window; byte lane bits are not part of the decode.
    function automatic reg_sel_e decode(input logic [WIN_BITS-3:0] widx);
        return widx == TH_OFS[WIN_BITS-1:2]      ? REG_TH      :
               widx == TL_OFS[WIN_BITS-1:2]      ? REG_TL      :
               widx == TCON_OFS[WIN_BITS-1:2]    ? REG_TCON    :
               widx == SYSTICK_OFS[WIN_BITS-1:2] ? REG_SYSTICK : REG_NONE;
    endfunction

endpackage

// File: rtl/timer_irq_ctrl_if.sv
// timer_irq_ctrl_if: data-memory bus seen by the timer
//   MemRead/MemWrite : read/write strobes (master -> slave)
//   Address          : byte address (master -> slave)
//   WriteData        : write data (master -> slave)
//   ReadData         : combinational read data (slave -> master)
interface timer_irq_ctrl_if;

    logic        MemRead;
    logic        MemWrite;
    logic [31:0] Address;
    logic [31:0] WriteData;
    logic [31:0] ReadData;

    modport master (
        output MemRead, MemWrite, Address, WriteData,
        input  ReadData
    );

    modport slave (
        input  MemRead, MemWrite, Address, WriteData,
        output ReadData
    );

endinterface

// File: rtl/timer_irq_ctrl_tick_gen.sv
// timer_irq_ctrl_tick_gen: prescaler producing one tick every PRESCALE enabled cycles
//   clk, reset : clock, async active-low reset
//   en         : count enable (TCON.EN)
//   clr        : restart the phase (TL write)
//   tick       : combinational, high in the last cycle of each period
module timer_irq_ctrl_tick_gen #(
    parameter int unsigned PRESCALE = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam logic [15:0] LAST = 16'(PRESCALE - 1);

    logic [15:0] pcnt_q;
    logic [15:0] pcnt_d;

    assign tick   = en && pcnt_q == LAST;
    assign pcnt_d = (!en || clr || tick) ? '0 : pcnt_q + 16'd1;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) pcnt_q <= '0;
        else        pcnt_q <= pcnt_d;
    end

endmodule

// File: rtl/timer_irq_ctrl.sv
// timer_irq_ctrl: memory-mapped reload timer with overflow interrupt and free-running SYSTICK
//   clk, reset : clock, async active-low reset
//   bus        : data-memory bus (slave modport), window of 32 bytes at BASE
//   PC31       : kernel-mode bit, masks IRQ while 1
//   IRQ        : level interrupt = ST & IE & ~PC31
module timer_irq_ctrl
    import timer_pkg::*;
#(
    parameter logic [31:0] BASE     = KERNEL_BASE,
    parameter int unsigned PRESCALE = 1
) (
    input  logic                   clk,
    input  logic                   reset,
    timer_irq_ctrl_if.slave        bus,
    input  logic                   PC31,
    output logic                   IRQ
);

    logic [31:0] th_q, th_d;
    logic [31:0] tl_q, tl_d;
    logic [2:0]  tcon_q, tcon_d;
    logic [31:0] systick_q, systick_d;

    logic     sel;
    reg_sel_e rsel;
    logic     wr_th, wr_tl, wr_tcon;
    logic     tick, ovf;
    logic     unused_lanes;

    assign unused_lanes = ^bus.Address[1:0];

    assign sel     = bus.Address[31:WIN_BITS] == BASE[31:WIN_BITS];
    assign rsel    = sel ? decode(bus.Address[WIN_BITS-1:2]) : REG_NONE;
    assign wr_th   = bus.MemWrite && rsel == REG_TH;
    assign wr_tl   = bus.MemWrite && rsel == REG_TL;
    assign wr_tcon = bus.MemWrite && rsel == REG_TCON;

    timer_irq_ctrl_tick_gen #(.PRESCALE(PRESCALE)) u_tick (
        .clk   (clk),
        .reset (reset),
        .en    (tcon_q[EN_BIT]),
        .clr   (wr_tl),
        .tick  (tick)
    );

    assign ovf = tick && tl_q == 32'hFFFF_FFFF;

    always_comb begin
        th_d      = wr_th ? bus.WriteData : th_q;
        // A TL write beats the tick; an overflow reloads the TH held before any same-cycle TH write.
        tl_d      = wr_tl ? bus.WriteData : tick ? (ovf ? th_q : tl_q + 32'd1) : tl_q;
        tcon_d    = tcon_q;
        if (wr_tcon) begin
            tcon_d[EN_BIT] = bus.WriteData[EN_BIT];
            tcon_d[IE_BIT] = bus.WriteData[IE_BIT];
        end
        // Setting wins over a software clear so an overflow is never lost.
        tcon_d[ST_BIT] = (ovf && tcon_q[IE_BIT]) ? 1'b1 :
                         (wr_tcon && !bus.WriteData[ST_BIT]) ? 1'b0 : tcon_q[ST_BIT];
        systick_d = systick_q + 32'd1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            th_q      <= '0;
            tl_q      <= '0;
            tcon_q    <= '0;
            systick_q <= '0;
        end else begin
            th_q      <= th_d;
            tl_q      <= tl_d;
            tcon_q    <= tcon_d;
            systick_q <= systick_d;
        end
    end

    assign bus.ReadData = !bus.MemRead        ? '0 :
                          rsel == REG_TH      ? th_q :
                          rsel == REG_TL      ? tl_q :
                          rsel == REG_TCON    ? {29'd0, tcon_q} :
                          rsel == REG_SYSTICK ? systick_q : '0;

    assign IRQ = tcon_q[ST_BIT] && tcon_q[IE_BIT] && !PC31;

endmodule

// File: tb/tb_timer_irq_ctrl.sv
// tb_timer_irq_ctrl: directed vector table plus hand-written sequences for timer_irq_ctrl
module tb_timer_irq_ctrl;

    localparam logic [31:0] A_TH   = 32'h4000_0000;
    localparam logic [31:0] A_TL   = 32'h4000_0004;
    localparam logic [31:0] A_TCON = 32'h4000_0008;
    localparam logic [31:0] A_SYS  = 32'h4000_0014;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        pc31 = 1'b0;
    logic        mem_read = 1'b0;
    logic        mem_write = 1'b0;
    logic [31:0] address = '0;
    logic [31:0] wdata = '0;
    logic        irq1, irq4;

    int n_cmp = 0;
    int n_bad = 0;

    timer_irq_ctrl_if b1 ();
    timer_irq_ctrl_if b4 ();

    assign b1.MemRead   = mem_read;
    assign b1.MemWrite  = mem_write;
    assign b1.Address   = address;
    assign b1.WriteData = wdata;
    assign b4.MemRead   = mem_read;
    assign b4.MemWrite  = mem_write;
    assign b4.Address   = address;
    assign b4.WriteData = wdata;

    timer_irq_ctrl #(.BASE(32'h4000_0000), .PRESCALE(1)) dut1 (
        .clk(clk), .reset(reset), .bus(b1), .PC31(pc31), .IRQ(irq1)
    );

    timer_irq_ctrl #(.BASE(32'h4000_0000), .PRESCALE(4)) dut4 (
        .clk(clk), .reset(reset), .bus(b4), .PC31(pc31), .IRQ(irq4)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        we;
        logic [31:0] waddr;
        logic [31:0] wd;
        logic [31:0] raddr;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[11];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        mem_write = 1'b1;
        address   = a;
        wdata     = d;
        cyc(1);
        mem_write = 1'b0;
    endtask

    task automatic rd(input logic [31:0] a, output logic [31:0] d1, output logic [31:0] d4);
        mem_read = 1'b1;
        address  = a;
        #1;
        d1 = b1.ReadData;
        d4 = b4.ReadData;
        mem_read = 1'b0;
    endtask

    task automatic rdc(input string name, input logic [31:0] a, input logic [31:0] exp);
        logic [31:0] d1, d4;
        rd(a, d1, d4);
        chk(name, d1, exp);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [31:0] d1, d4, s0, s1;
        vecs[0]  = '{1'b1, A_TH,          32'h1234_5678, A_TH,          32'h1234_5678};
        vecs[1]  = '{1'b1, A_TL,          32'h0000_00FF, A_TL,          32'h0000_00FF};
        vecs[2]  = '{1'b1, A_TCON,        32'hFFFF_FFFA, A_TCON,        32'h0000_0002};
        vecs[3]  = '{1'b1, A_TCON,        32'hFFFF_FFFC, A_TCON,        32'h0000_0000};
        vecs[4]  = '{1'b1, 32'h4000_000C, 32'h0000_DEAD, 32'h4000_000C, 32'h0000_0000};
        vecs[5]  = '{1'b1, 32'h4000_0010, 32'h0000_0001, 32'h4000_0010, 32'h0000_0000};
        vecs[6]  = '{1'b1, 32'h4000_0020, 32'h0000_0BAD, A_TH,          32'h1234_5678};
        vecs[7]  = '{1'b1, 32'h3FFF_FFFC, 32'h0000_0BAD, A_TL,          32'h0000_00FF};
        vecs[8]  = '{1'b1, 32'h4000_0005, 32'h0000_0055, 32'h4000_0007, 32'h0000_0055};
        vecs[9]  = '{1'b0, 32'h0,         32'h0,         32'h4000_0020, 32'h0000_0000};
        vecs[10] = '{1'b1, 32'h4000_0002, 32'h0000_ABCD, A_TH,          32'h0000_ABCD};

        // reset state
        rdc("rst_th", A_TH, 32'h0);
        rdc("rst_tl", A_TL, 32'h0);
        rdc("rst_tcon", A_TCON, 32'h0);
        rdc("rst_systick", A_SYS, 32'h0);
        chk("rst_irq", {31'd0, irq1}, 32'h0);
        cyc(2);
        reset = 1'b1;
        cyc(1);

        // register/decode table, timers stopped
        for (int i = 0; i < 11; i++) begin
            if (vecs[i].we) wr(vecs[i].waddr, vecs[i].wd);
            else cyc(1);
            rd(vecs[i].raddr, d1, d4);
            chk($sformatf("vec%0d_p1", i), d1, vecs[i].exp);
            chk($sformatf("vec%0d_p4", i), d4, vecs[i].exp);
        end

        // MemRead low forces zero
        address = A_TH;
        #1;
        chk("noread_zero", b1.ReadData, 32'h0);

        // SYSTICK delta and write ignored
        rd(A_SYS, s0, d4);
        cyc(5);
        rd(A_SYS, s1, d4);
        chk("systick_delta5", s1 - s0, 32'd5);
        rd(A_SYS, s0, d4);
        wr(A_SYS, 32'h0);
        rd(A_SYS, s1, d4);
        chk("systick_wr_ignored", s1 - s0, 32'd1);

        // overflow and reload
        wr(A_TH, 32'hFFFF_FFF0);
        wr(A_TL, 32'hFFFF_FFFE);
        wr(A_TCON, 32'h3);
        cyc(1);
        rdc("ovf_pre_tl", A_TL, 32'hFFFF_FFFF);
        chk("ovf_pre_irq", {31'd0, irq1}, 32'h0);
        cyc(1);
        rdc("ovf_tl", A_TL, 32'hFFFF_FFF0);
        rdc("ovf_tcon", A_TCON, 32'h7);
        chk("ovf_irq", {31'd0, irq1}, 32'h1);
        wr(A_TCON, 32'h3);
        chk("clr_irq", {31'd0, irq1}, 32'h0);
        rdc("clr_tcon", A_TCON, 32'h3);
        wr(A_TCON, 32'h0);

        // kernel-mode masking
        pc31 = 1'b1;
        wr(A_TH, 32'h0);
        wr(A_TL, 32'hFFFF_FFFF);
        wr(A_TCON, 32'h3);
        cyc(1);
        chk("mask_irq", {31'd0, irq1}, 32'h0);
        rdc("mask_tcon", A_TCON, 32'h7);
        pc31 = 1'b0;
        #1;
        chk("unmask_irq", {31'd0, irq1}, 32'h1);
        wr(A_TCON, 32'h0);

        // clear on the exact overflow cycle: set wins
        wr(A_TL, 32'hFFFF_FFFE);
        wr(A_TCON, 32'h3);
        cyc(1);
        wr(A_TCON, 32'h3);
        rdc("coll_tcon", A_TCON, 32'h7);
        chk("coll_irq", {31'd0, irq1}, 32'h1);
        rdc("coll_tl", A_TL, 32'h0);
        cyc(1);
        chk("coll_irq_hold", {31'd0, irq1}, 32'h1);

        // TL write during overflow tick: write wins, ST still set
        wr(A_TCON, 32'h3);
        chk("wtl_pre_irq", {31'd0, irq1}, 32'h0);
        wr(A_TL, 32'hFFFF_FFFF);
        wr(A_TL, 32'h0000_0100);
        rdc("wtl_tl", A_TL, 32'h0000_0100);
        rdc("wtl_tcon", A_TCON, 32'h7);

        // disabling write still lets that cycle's tick land
        wr(A_TCON, 32'h0);
        rdc("enoff_tl", A_TL, 32'h0000_0101);
        rdc("enoff_tcon", A_TCON, 32'h0);
        cyc(2);
        rdc("enoff_stopped", A_TL, 32'h0000_0101);

        // prescaler 4 (dut4)
        wr(A_TL, 32'h0);
        wr(A_TCON, 32'h1);
        cyc(11);
        rd(A_TL, d1, d4);
        chk("pre_tl_11", d4, 32'd2);
        cyc(1);
        rd(A_TL, d1, d4);
        chk("pre_tl_12", d4, 32'd3);
        cyc(2);
        wr(A_TL, 32'd10);
        cyc(3);
        rd(A_TL, d1, d4);
        chk("pre_phase_hold", d4, 32'd10);
        cyc(1);
        rd(A_TL, d1, d4);
        chk("pre_phase_tick", d4, 32'd11);
        wr(A_TCON, 32'h0);

        // reset mid-count
        wr(A_TH, 32'h0);
        wr(A_TL, 32'hFFFF_FFFD);
        wr(A_TCON, 32'h3);
        cyc(2);
        rdc("rmid_tl_ff", A_TL, 32'hFFFF_FFFF);
        cyc(1);
        chk("rmid_irq_pre", {31'd0, irq1}, 32'h1);
        reset = 1'b0;
        #1;
        rdc("rmid_tl", A_TL, 32'h0);
        rdc("rmid_tcon", A_TCON, 32'h0);
        rdc("rmid_systick", A_SYS, 32'h0);
        chk("rmid_irq", {31'd0, irq1}, 32'h0);
        reset = 1'b1;
        cyc(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/timer_irq_ctrl.md
# timer_irq_ctrl

Memory-mapped timer peripheral that produces the `IRQ` line consumed by the PC/IF-ID stage, plus a free-running cycle counter. It sits on the data-memory bus beside data RAM and decodes its own address window. It raises a level interrupt on counter overflow and holds it until software clears it. The line is masked while the core runs in kernel mode (`PC31` = 1).

## Interface
- `BASE`, default 32'h4000_0000: byte base address of the register window.
- `PRESCALE`, default 1: clock cycles per TL increment; legal range 1..65535.

- `clk`  in  1  system clock, rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `MemRead`  in  1  bus read strobe.
- `MemWrite`  in  1  bus write strobe, one word per cycle.
- `Address`  in  32  byte address; word-aligned, bits [1:0] ignored.
- `WriteData`  in  32  write data.
- `PC31`  in  1  kernel-mode bit of the fetch PC; 1 masks IRQ.
- `ReadData`  out  32  combinational read data; 0 when not selected or `MemRead` = 0.
- `IRQ`  out  1  level interrupt request to the PC/IF-ID stage.

## Operation
- Register map, offsets from `BASE`:
  - 0x00 TH: reload value, R/W.
  - 0x04 TL: count, R/W.
  - 0x08 TCON: R/W; bits [31:3] read 0.
    - [0] EN: count enable.
    - [1] IE: interrupt enable.
    - [2] ST: status.
  - 0x14 SYSTICK: read-only. Writes to it are ignored.
- Address decoding:
  - Addresses outside {0x00, 0x04, 0x08, 0x14} within the window read 0 and ignore writes.
  - Addresses outside the window are not selected.
- Prescaler:
  - `pcnt` counts 0..PRESCALE-1 while EN = 1.
  - A tick occurs on the cycle `pcnt` = PRESCALE-1. `pcnt` then wraps to 0.
  - `pcnt` is cleared when EN = 0 and on any write to TL.
- Tick behaviour:
  - If TL ≠ 32'hFFFF_FFFF: TL <= TL + 1.
  - If TL = 32'hFFFF_FFFF (overflow): TL <= TH, and ST <= 1 if IE = 1.
- Clearing ST: software writes TCON with bit 2 = 0. Writing bit 2 = 1 leaves ST unchanged; software cannot set ST.
- `IRQ` = ST & IE & ~PC31.
  - Combinational from registers and `PC31`.
  - ST stays pending while masked and asserts `IRQ` once `PC31` returns to 0.
- SYSTICK: increments by 1 every cycle regardless of EN. Wraps at 2^32 to 0.
- Simultaneous events in the same cycle:
  - Write to TL and tick: the write wins for TL. An overflow tick still sets ST (IE = 1).
  - Write clearing ST and overflow with IE = 1: ST = 1. Set wins, so no interrupt is lost.
  - Write to TH and overflow: TL reloads the old TH. The new TH takes effect from the next overflow.
  - Write to TCON with EN = 0 and a tick: the tick still takes effect. Counting stops from the next cycle.

## Timing
- Reset (`reset` = 0, asynchronous): TH, TL, TCON, SYSTICK and `pcnt` all go to 0. `IRQ` = 0.
- Reset may assert mid-count; all state clears immediately and any pending interrupt is lost.
- Writes: `WriteData` is sampled on the rising edge. The new value is readable in the next cycle.
- Reads: combinational, zero latency. A read and a write to the same register in one cycle returns the old value.
- Interrupt latency:
  - ST rises on the edge at which TL leaves 32'hFFFF_FFFF.
  - `IRQ` asserts in the same cycle as ST, subject to `PC31`.
- With PRESCALE = 1, TH = T, TL = T, EN = IE = 1: overflow repeats every 2^32 - T cycles.

## Structure
- Shared package `timer_pkg` holds:
  - Offset constants: TH_OFS, TL_OFS, TCON_OFS, SYSTICK_OFS.
  - TCON bit indices: EN_BIT, IE_BIT, ST_BIT.
  - The kernel window base.
- No sub-module is required. The prescaler may be split out as `tick_gen`; it is the only natural sub-module.

## Test plan
- Reset mid-count:
  - Stimulus: TH = 0, TL = 32'hFFFF_FFFD, TCON = 3; release reset, count 3 cycles, then pull `reset` low.
  - Response: TL = 0, ST = 0, `IRQ` = 0 immediately.
- Overflow and reload:
  - Stimulus: TH = 32'hFFFF_FFF0, TL = 32'hFFFF_FFFE, TCON = 3, PRESCALE = 1.
  - Response: after 2 cycles TL = 32'hFFFF_FFF0, ST = 1, `IRQ` = 1.
  - Writing TCON = 3 clears `IRQ` on the next cycle.
- Kernel-mode masking:
  - Stimulus: force overflow with `PC31` = 1.
  - Response: `IRQ` = 0 and TCON reads 7. Dropping `PC31` to 0 gives `IRQ` = 1 in the same cycle.
- Clear-versus-set collision:
  - Stimulus: write TCON = 3 on the exact overflow cycle.
  - Response: TCON reads 7 and `IRQ` stays 1.
- Prescaler:
  - Stimulus: PRESCALE = 4, TL = 0, EN = 1 for 12 cycles.
  - Response: TL = 3. A TL write mid-period restarts the 4-cycle phase.
- Bus decode:
  - Read 0x4000_0010 → 0. Read `BASE`+0x14 twice, 5 cycles apart → difference 5.
  - Write to SYSTICK → no effect. `MemRead` = 0 → `ReadData` = 0.
